// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access size codes, FSM state
// encoding and the alignment rule used when the misalignment check is built in.
package dmem_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Reserved size is always an error; bytes can never be misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational: on a tie the requester that
// did not win last time is chosen; a single valid requester always wins.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       any_valid_o
);

  assign any_valid_o = |valid_i;
  assign grant_o     = (valid_i == 2'b11) ? ~last_grant_i : valid_i[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between r0 (CPU LSU) and r1 (DMA/debug), one access in flight.
// Accept -> 1-cycle memory issue -> held response; optional alignment check under DMEM_ARB_MISALIGN_CHECK_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0]            req_we_i,
  input  logic [3:0]            req_size_i,
  input  logic [2*ADDR_W-1:0]   req_addr_i,
  input  logic [2*DATA_W-1:0]   req_wdata_i,
  output logic [1:0]            rsp_valid_o,
  input  logic [1:0]            rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_we_o,
  output logic [1:0]            mem_size_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  state_e              state_q;
  logic                last_grant_q;
  logic                gnt_q;
  logic                we_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic                arb_gnt;
  logic                any_vld;
  logic                sel_we;
  logic [1:0]          sel_size;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                acc_err;
  logic [DATA_W-1:0]   rdata_d;

  rr_arb2 u_arb (
    .valid_i      (req_valid_i),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_gnt),
    .any_valid_o  (any_vld)
  );

  assign sel_we    = arb_gnt ? req_we_i[1]                      : req_we_i[0];
  assign sel_size  = arb_gnt ? req_size_i[3:2]                  : req_size_i[1:0];
  assign sel_addr  = arb_gnt ? req_addr_i[2*ADDR_W-1:ADDR_W]    : req_addr_i[ADDR_W-1:0];
  assign sel_wdata = arb_gnt ? req_wdata_i[2*DATA_W-1:DATA_W]   : req_wdata_i[DATA_W-1:0];

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  assign acc_err = misaligned(sel_size, sel_addr[1:0]);
`else
  assign acc_err = 1'b0;
`endif

  // Stores report zero data; loads take the memory's zero-extended read.
  assign rdata_d = we_q ? '0 : mem_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_vld) begin
            gnt_q        <= arb_gnt;
            last_grant_q <= arb_gnt;
            we_q         <= sel_we;
            size_q       <= sel_size;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            rdata_q      <= '0;
            err_q        <= acc_err;
            // A rejected access never touches memory and answers one cycle early.
            state_q      <= acc_err ? ST_RESP : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rdata_q <= rdata_d;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i[gnt_q]) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == ST_IDLE && any_vld) ? (arb_gnt ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid_o = (state_q == ST_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  assign mem_we_o    = (state_q == ST_ISSUE) & we_q;
  assign mem_size_o  = size_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: byte-array memory behind the DUT, a shadow
// reference memory for expected load data, and per-requester expected-response queues.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [3:0]  req_size;
  logic [23:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic        rsp_err, mem_we;
  logic [1:0]  mem_size;
  logic [11:0] mem_addr;

  logic        v    [2];
  logic        we_a [2];
  logic [1:0]  sz_a [2];
  logic [11:0] ad_a [2];
  logic [31:0] wd_a [2];

  logic [7:0]  env_mem [4096];
  logic [7:0]  ref_mem [4096];
  exp_t        exp_q0 [$];
  exp_t        exp_q1 [$];
  int          gnt_log [$];
  int          n_cmp;
  int          n_bad;

  assign req_valid = {v[1], v[0]};
  assign req_we    = {we_a[1], we_a[0]};
  assign req_size  = {sz_a[1], sz_a[0]};
  assign req_addr  = {ad_a[1], ad_a[0]};
  assign req_wdata = {wd_a[1], wd_a[0]};

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_size_i  (req_size),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .mem_we_o    (mem_we),
    .mem_size_o  (mem_size),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte memory, zero-extending reads.
  logic [11:0] ma1, ma2, ma3;
  always_comb begin
    ma1 = mem_addr + 12'd1;
    ma2 = mem_addr + 12'd2;
    ma3 = mem_addr + 12'd3;
    case (mem_size)
      2'd1:    mem_rdata = {24'd0, env_mem[mem_addr]};
      2'd2:    mem_rdata = {16'd0, env_mem[ma1], env_mem[mem_addr]};
      default: mem_rdata = {env_mem[ma3], env_mem[ma2], env_mem[ma1], env_mem[mem_addr]};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic bad_access(input logic [1:0] sz, input logic [11:0] a);
    return (sz == 2'd3) || (sz == 2'd2 && a[0]) || (sz == 2'd0 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_read(input logic [1:0] sz, input logic [11:0] a);
    logic [31:0] w;
    w = {ref_mem[a + 12'd3], ref_mem[a + 12'd2], ref_mem[a + 12'd1], ref_mem[a]};
    if (sz == 2'd1) return w & 32'h0000_00ff;
    if (sz == 2'd2) return w & 32'h0000_ffff;
    return w;
  endfunction

  task automatic ref_write(input logic [1:0] sz, input logic [11:0] a, input logic [31:0] d);
    ref_mem[a] = d[7:0];
    if (sz != 2'd1) ref_mem[a + 12'd1] = d[15:8];
    if (sz != 2'd1 && sz != 2'd2) begin
      ref_mem[a + 12'd2] = d[23:16];
      ref_mem[a + 12'd3] = d[31:24];
    end
  endtask

  task automatic send(input int r, input logic we, input logic [1:0] sz,
                      input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    v[r] = 1'b1; we_a[r] = we; sz_a[r] = sz; ad_a[r] = a; wd_a[r] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[r] && n < 200);
    chk($sformatf("accept_r%0d", r), {31'd0, req_ready[r]}, 32'd1);
    e.err   = CHK && bad_access(sz, a);
    e.rdata = (we || e.err) ? 32'd0 : ref_read(sz, a);
    if (we && !e.err) ref_write(sz, a, d);
    if (r == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    @(posedge clk); #1;
    v[r] = 1'b0;
  endtask

  task automatic timed(input string tag, input int r, input logic we, input logic [1:0] sz,
                       input logic [11:0] a, input logic [31:0] d,
                       input int exp_lat, input int exp_we, input int exp_we_at);
    int lat, wes, we_at;
    lat = 0; wes = 0; we_at = 0;
    send(r, we, sz, a, d);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (mem_we) begin
        wes++;
        if (we_at == 0) we_at = k;
      end
      if (rsp_valid[r] && lat == 0) lat = k;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_we_cnt"}, wes, exp_we);
    chk({tag, "_we_at"}, we_at, exp_we_at);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rsp_valid[0] && rsp_ready[0]) begin
          if (exp_q0.size() == 0) chk("rsp0_unexpected", {31'd0, rsp_valid[0]}, 32'd0);
          else begin
            e = exp_q0.pop_front();
            chk("rsp0_rdata", rsp_rdata, e.rdata);
            chk("rsp0_err", {31'd0, rsp_err}, {31'd0, e.err});
          end
          gnt_log.push_back(0);
        end
        if (rsp_valid[1] && rsp_ready[1]) begin
          if (exp_q1.size() == 0) chk("rsp1_unexpected", {31'd0, rsp_valid[1]}, 32'd0);
          else begin
            e = exp_q1.pop_front();
            chk("rsp1_rdata", rsp_rdata, e.rdata);
            chk("rsp1_err", {31'd0, rsp_err}, {31'd0, e.err});
          end
          gnt_log.push_back(1);
        end
      end
    end
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((exp_q0.size() + exp_q1.size()) != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_drain"}, exp_q0.size() + exp_q1.size(), 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_size"}, {30'd0, mem_size}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; we_a[i] = 1'b0; sz_a[i] = 2'd0; ad_a[i] = 12'd0; wd_a[i] = 32'd0;
    end
    for (int i = 0; i < 4096; i++) begin
      env_mem[i] = 8'd0;
      ref_mem[i] = 8'd0;
    end
    fork
      monitor();
      forever begin
        @(posedge clk);
        if (mem_we) begin
          env_mem[mem_addr] = mem_wdata[7:0];
          if (mem_size != 2'd1) env_mem[ma1] = mem_wdata[15:8];
          if (mem_size != 2'd1 && mem_size != 2'd2) begin
            env_mem[ma2] = mem_wdata[23:16];
            env_mem[ma3] = mem_wdata[31:24];
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
    rst_n = 1'b1;

    // Store timing, then read-back by the other requester.
    timed("t1_sw", 0, 1'b1, 2'd0, 12'h010, 32'hDEAD_BEEF, 2, 1, 1);
    send(1, 1'b0, 2'd0, 12'h010, 32'd0);
    drain("t1");

    // Sub-word zero-extended loads.
    send(0, 1'b1, 2'd0, 12'h010, 32'h1122_3344);
    send(1, 1'b0, 2'd1, 12'h013, 32'd0);
    send(1, 1'b0, 2'd2, 12'h012, 32'd0);
    drain("t3");
    chk("t3_ref_lbu", ref_read(2'd1, 12'h013), 32'h0000_0011);
    chk("t3_ref_lhu", ref_read(2'd2, 12'h012), 32'h0000_1122);

    // Both requesters always valid: strict alternation.
    gnt_log.delete();
    fork
      for (int i = 0; i < 4; i++) send(0, 1'b0, 2'd0, 12'h010, 32'd0);
      for (int i = 0; i < 4; i++) send(1, 1'b0, 2'd2, 12'(12'h014 + 2 * i), 32'd0);
    join
    drain("t2");
    chk("t2_count", gnt_log.size(), 8);
    for (int i = 0; i < gnt_log.size(); i++) chk($sformatf("t2_grant%0d", i), gnt_log[i], i % 2);

    // Stalled response blocks acceptance of the other requester.
    rsp_ready = 2'b10;
    fork send(0, 1'b0, 2'd0, 12'h010, 32'd0); join_none
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[0] && n < 20);
    chk("t4_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
    fork send(1, 1'b0, 2'd0, 12'h014, 32'd0); join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t4_hold_valid%0d", i), {30'd0, rsp_valid}, 32'd1);
      chk($sformatf("t4_hold_rdata%0d", i), rsp_rdata, 32'h1122_3344);
      chk($sformatf("t4_hold_ready%0d", i), {30'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("t4_r1_granted", {30'd0, req_ready}, 32'd2);
    drain("t4");

    // Misaligned halfword store.
    if (CHK) timed("t6_sh", 0, 1'b1, 2'd2, 12'h011, 32'h0000_ABCD, 1, 0, 0);
    else     timed("t6_sh", 0, 1'b1, 2'd2, 12'h011, 32'h0000_ABCD, 2, 1, 1);
    send(1, 1'b0, 2'd0, 12'h010, 32'd0);
    drain("t6");

    // Reset in the middle of a store's issue cycle.
    @(posedge clk); #1;
    v[0] = 1'b1; we_a[0] = 1'b1; sz_a[0] = 2'd0; ad_a[0] = 12'h020; wd_a[0] = 32'h5;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[0] && n < 20);
    chk("t5_accept", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk); #1;
    v[0] = 1'b0;
    chk("t5_we_issue", {31'd0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_idle_outputs("t5_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    gnt_log.delete();
    fork
      send(0, 1'b0, 2'd0, 12'h020, 32'd0);
      send(1, 1'b0, 2'd0, 12'h010, 32'd0);
    join
    drain("t5");
    chk("t5_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("t5_first", gnt_log[0], 0);
      chk("t5_second", gnt_log[1], 1);
    end
    chk("t5_mem_020", {env_mem[12'h023], env_mem[12'h022], env_mem[12'h021], env_mem[12'h020]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
